// File: rtl/priority_rr_arbiter.sv
// priority_rr_arbiter: 16-way fixed/round-robin arbiter with done handshake and hold timeout
module priority_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        rr_mode,
  input  logic        done,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic [7:0]  gnt_code,
  output logic        timeout
);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [15:0] gnt_q, gnt_d;
  logic [7:0] code_q, code_d;
  logic [3:0] last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic timeout_q, timeout_d;
  logic [3:0] fp_idx, rr_idx, win;
  logic rr_hit, rel_a, rel_b, rel_c;
  always_comb begin
    fp_idx = 4'd0;
    rr_idx = 4'd0;
    rr_hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (req[i]) fp_idx = 4'(i);
      if (req[i] && 4'(i) < last_q) begin
        rr_idx = 4'(i);
        rr_hit = 1'b1;
      end
    end
    win = (rr_mode && rr_hit) ? rr_idx : fp_idx;
  end
  // last_q always equals the current owner while in GRANT
  assign rel_a = done;
  assign rel_b = !req[last_q];
  assign rel_c = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    code_d = code_q;
    last_d = last_q;
    hold_d = hold_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        gnt_d = 16'd1 << win;
        code_d = {4'b0, win};
        last_d = win;
        hold_d = '0;
      end
    end else if (rel_a || rel_b || rel_c) begin
      state_d = IDLE;
      gnt_d = '0;
      code_d = 8'hF0;
      hold_d = '0;
      timeout_d = rel_c && !rel_a && !rel_b;
    end else begin
      hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      code_q <= 8'hF0;
      last_q <= '0;
      hold_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      code_q <= code_d;
      last_q <= last_d;
      hold_q <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_code = code_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_priority_rr_arbiter.sv
// tb_priority_rr_arbiter: directed and random checks against a cycle-level reference model
module tb_priority_rr_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] req = 16'hFFFF;
  logic rr_mode = 1'b0;
  logic done = 1'b0;
  logic [15:0] gnt;
  logic gnt_valid;
  logic [7:0] gnt_code;
  logic timeout;
  int n_chk = 0;
  int n_fail = 0;
  bit m_busy = 0;
  int m_owner = 0;
  int m_last = 0;
  int m_held = 0;
  bit m_to = 0;

  priority_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_code(gnt_code), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [15:0] r, input bit rr, input int last);
    if (rr)
      for (int i = last - 1; i >= 0; i--) if (r[i]) return i;
    for (int i = 15; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_last = 0; m_held = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (req != 0) begin
        m_owner = pick(req, rr_mode, m_last);
        m_last = m_owner; m_busy = 1; m_held = 1;
      end
    end else if (done || !req[m_owner] || m_held == MH) begin
      m_to = !done && req[m_owner] && m_held == MH;
      m_busy = 0; m_held = 0;
    end else begin
      m_to = 0; m_held++;
    end
    #1;
    chk("gnt", gnt, m_busy ? 16'(1 << m_owner) : 16'h0);
    chk("gnt_code", {8'h0, gnt_code}, m_busy ? 16'(m_owner) : 16'h00F0);
    chk("gnt_valid", {15'h0, gnt_valid}, {15'h0, m_busy});
    chk("timeout", {15'h0, timeout}, {15'h0, m_to});
    chk("onehot0", {15'h0, $onehot0(gnt)}, 16'h1);
  endtask

  initial begin
    step(); step();
    chk("rst_code", {8'h0, gnt_code}, 16'h00F0);
    rst = 0; rr_mode = 0; req = 16'h8001;
    step(); chk("fp_gnt", gnt, 16'h8000);
    done = 1; step(); chk("done_rel", gnt, 16'h0);
    done = 0; step(); chk("regrant", gnt, 16'h8000);
    done = 1; step(); done = 0;
    rst = 1; step(); rst = 0;
    rr_mode = 1; req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      step(); chk("rr_order", {8'h0, gnt_code}, 16'((15 - k) & 15));
      done = 1; step(); chk("rr_gap", gnt, 16'h0); done = 0;
    end
    rr_mode = 0; req = 16'h0;
    step();
    req = 16'h0008;
    step();
    for (int k = 0; k < 3; k++) begin step(); chk("hold", gnt, 16'h0008); end
    step(); chk("to_drop", gnt, 16'h0); chk("to_pulse", {15'h0, timeout}, 16'h1);
    step(); chk("to_regrant", gnt, 16'h0008); chk("to_clear", {15'h0, timeout}, 16'h0);
    req = 16'h0; step(); step();
    req = 16'h0020; step(); chk("g5", gnt, 16'h0020);
    req = 16'h0; step(); chk("withdraw", gnt, 16'h0); chk("wd_to", {15'h0, timeout}, 16'h0);
    req = 16'h0008; step(); step(); step(); step();
    done = 1; step(); done = 0;
    chk("done_to_drop", gnt, 16'h0); chk("done_to", {15'h0, timeout}, 16'h0);
    req = 16'h0; step();
    req = 16'h0040; step(); step(); step();
    rst = 1; step();
    chk("mid_rst_gnt", gnt, 16'h0); chk("mid_rst_to", {15'h0, timeout}, 16'h0);
    rst = 0; req = 16'h0101; rr_mode = 1;
    step(); chk("post_rst_rr", {8'h0, gnt_code}, 16'h0008);
    for (int k = 0; k < 400; k++) begin
      req = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom) & 16'($urandom) & 16'($urandom);
      rr_mode = 1'($urandom_range(0, 1));
      done = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 60) == 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
